// File: rtl/wave_gen_pkg.sv
// Shared constants for the phase-accumulator waveform generator.
// Func encodings, noise LFSR taps and default seed.
package wave_gen_pkg;

  localparam logic [2:0] FUNC_SAW_UP = 3'b000;
  localparam logic [2:0] FUNC_SAW_DN = 3'b001;
  localparam logic [2:0] FUNC_TRI    = 3'b010;
  localparam logic [2:0] FUNC_SQUARE = 3'b011;
  localparam logic [2:0] FUNC_SINE   = 3'b100;
  localparam logic [2:0] FUNC_PULSE  = 3'b101;
  localparam logic [2:0] FUNC_NOISE  = 3'b110;
  localparam logic [2:0] FUNC_STAIR  = 3'b111;

  // x^16+x^14+x^13+x^11+1 as right-shifting Fibonacci taps
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/wave_gen_sine_rom.sv
// Quarter-wave sine ROM with quadrant mirroring, offset-binary output.
// Only compiled when WAVE_GEN_SINE_EN is defined.
`ifdef WAVE_GEN_SINE_EN
module wave_gen_sine_rom #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] p,
  output logic [DATA_W-1:0] sine
);

  localparam logic [6:0] ROM [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd107, 7'd108, 7'd110, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127
  };

  logic [5:0] idx;
  logic [5:0] mir;
  logic [6:0] mag;
  logic [DATA_W+6:0] ext;
  logic [DATA_W-2:0] hm;

  // narrow samples pad the index with zeros below the phase bits
  if (DATA_W >= 8) begin : g_wide
    assign idx = p[DATA_W-3 -: 6];
  end else begin : g_narrow
    assign idx = {p[DATA_W-3:0], {(8-DATA_W){1'b0}}};
  end

  assign mir  = p[DATA_W-2] ? ~idx : idx;
  assign mag  = ROM[mir];
  assign ext  = {mag, {DATA_W{1'b0}}};
  assign hm   = (DATA_W-1)'(ext >> 8);
  assign sine = p[DATA_W-1] ? {1'b0, ~hm} : {1'b1, hm};

endmodule
`endif

// File: rtl/wave_gen_param.sv
// DDS waveform generator: phase accumulator, raw stage, amplitude stage.
// Define WAVE_GEN_SINE_EN to get a ROM sine on func 100.
module wave_gen_param
  import wave_gen_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          PHASE_W   = 16,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2:0]         func,
  input  logic [PHASE_W-1:0] step,
  input  logic [DATA_W-1:0]  duty,
  input  logic [DATA_W-1:0]  amp,
  input  logic               sync_req,
  output logic [DATA_W-1:0]  wave,
  output logic               wave_valid,
  output logic               wrap,
  output logic [2:0]         func_active
);

  localparam logic [DATA_W-1:0] MAX = '1;
  localparam logic [DATA_W-1:0] MID =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] STAIR =
    {3'b111, {(DATA_W-3){1'b0}}};

  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W:0]    sum;
  logic [15:0]         lfsr;
  logic [DATA_W-1:0]   raw;
  logic [DATA_W-1:0]   raw_d;
  logic                v1;
  logic [DATA_W-1:0]   p;
  logic [DATA_W:0]     q;
  logic [DATA_W-1:0]   sine;
  logic [DATA_W:0]     amp1;
  logic [2*DATA_W:0]   prod;

  assign sum  = {1'b0, acc} + {1'b0, step};
  assign p    = acc[PHASE_W-1 -: DATA_W];
  assign q    = acc[PHASE_W-1 -: DATA_W+1];
  assign amp1 = {1'b0, amp} + {{DATA_W{1'b0}}, 1'b1};
  assign prod = {{(DATA_W+1){1'b0}}, raw}
              * {{DATA_W{1'b0}}, amp1};

`ifdef WAVE_GEN_SINE_EN
  wave_gen_sine_rom #(
    .DATA_W(DATA_W)
  ) u_sine (
    .p    (p),
    .sine (sine)
  );
`else
  assign sine = MID;
`endif

  always_comb begin
    raw_d = '0;
    unique case (func_active)
      FUNC_SAW_UP: raw_d = p;
      FUNC_SAW_DN: raw_d = ~p;
      FUNC_TRI:    raw_d = q[DATA_W] ? ~q[DATA_W-1:0]
                                     : q[DATA_W-1:0];
      FUNC_SQUARE: raw_d = p[DATA_W-1] ? MAX : '0;
      FUNC_SINE:   raw_d = sine;
      FUNC_PULSE:  raw_d = (p < duty) ? MAX : '0;
      FUNC_NOISE:  raw_d = lfsr[15 -: DATA_W];
      FUNC_STAIR:  raw_d = p & STAIR;
      default:     raw_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      wrap        <= 1'b0;
      func_active <= FUNC_SAW_UP;
      lfsr        <= LFSR_SEED;
      raw         <= '0;
      wave        <= '0;
      v1          <= 1'b0;
      wave_valid  <= 1'b0;
    end else begin
      if (sync_req) begin
        acc  <= '0;
        wrap <= 1'b0;
      end else if (en) begin
        acc  <= sum[PHASE_W-1:0];
        wrap <= sum[PHASE_W];
      end else begin
        wrap <= 1'b0;
      end
      // new function only starts on a period boundary
      if (sync_req || !en || wrap)
        func_active <= func;
      if (en)
        lfsr <= lfsr_next(lfsr);
      raw        <= raw_d;
      wave       <= DATA_W'(prod >> DATA_W);
      v1         <= en;
      wave_valid <= v1;
    end
  end

endmodule

// File: tb/tb_wave_gen_param.sv
// Scoreboard bench for wave_gen_param (DATA_W=8, PHASE_W=16).
// Arithmetic reference model feeds a queue popped by a monitor.
module tb_wave_gen_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  func;
  logic [15:0] step;
  logic [7:0]  duty;
  logic [7:0]  amp;
  logic        sync_req;
  logic [7:0]  wave;
  logic        wave_valid;
  logic        wrap;
  logic [2:0]  func_active;

  always #5 clk = ~clk;

  wave_gen_param #(
    .DATA_W    (8),
    .PHASE_W   (16),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .func        (func),
    .step        (step),
    .duty        (duty),
    .amp         (amp),
    .sync_req    (sync_req),
    .wave        (wave),
    .wave_valid  (wave_valid),
    .wrap        (wrap),
    .func_active (func_active)
  );

  typedef struct {
    int    wave;
    bit    wv;
    bit    wr;
    int    fa;
    string tag;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  string tag = "reset";

  int m_acc, m_lfsr, m_fa, m_raw, m_wave;
  bit m_wv, m_v1, m_wrap;

  function automatic int ref_raw(int f, int a, int l, int d);
    int pos;
    int t;
    pos = a / 256;
    t   = a / 128;
    case (f)
      0:       return pos;
      1:       return 255 - pos;
      2:       return (t < 256) ? t : 511 - t;
      3:       return (pos >= 128) ? 255 : 0;
      4:       return 128;
      5:       return (pos < d) ? 255 : 0;
      6:       return l / 256;
      default: return (pos / 32) * 32;
    endcase
  endfunction

  function automatic int ref_lfsr(int l);
    int b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
    return (l >> 1) | (b << 15);
  endfunction

  // predict the outcome of the coming rising edge, then wait a cycle
  task automatic tick();
    int   nraw;
    int   s;
    exp_t e;
    if (rst) begin
      m_acc  = 0;
      m_fa   = 0;
      m_lfsr = 'hACE1;
      m_raw  = 0;
      m_wave = 0;
      m_wv   = 0;
      m_v1   = 0;
      m_wrap = 0;
    end else begin
      nraw   = ref_raw(m_fa, m_acc, m_lfsr, int'(duty));
      m_wave = (m_raw * (int'(amp) + 1)) / 256;
      m_raw  = nraw;
      m_wv   = m_v1;
      m_v1   = en;
      if (sync_req || !en || m_wrap)
        m_fa = int'(func);
      s = m_acc + int'(step);
      if (sync_req) begin
        m_acc  = 0;
        m_wrap = 0;
      end else if (en) begin
        m_wrap = (s >= 65536);
        m_acc  = s % 65536;
      end else begin
        m_wrap = 0;
      end
      if (en)
        m_lfsr = ref_lfsr(m_lfsr);
    end
    e.wave = m_wave;
    e.wv   = m_wv;
    e.wr   = m_wrap;
    e.fa   = m_fa;
    e.tag  = tag;
    sbq.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ($isunknown({wave, wave_valid, wrap, func_active})
            || int'(wave) != e.wave
            || wave_valid !== e.wv
            || wrap !== e.wr
            || int'(func_active) != e.fa) begin
          errors++;
          $display("FAIL %s: got wave=%0d valid=%0b wrap=%0b fa=%0d, expected wave=%0d valid=%0b wrap=%0b fa=%0d",
                   e.tag, wave, wave_valid, wrap, func_active,
                   e.wave, e.wv, e.wr, e.fa);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sync_req = 1'b0;
    func = 3'd0; step = 16'd0; duty = 8'd0; amp = 8'd255;
    tag = "reset";
    tick();
    tick();
    rst = 1'b0; en = 1'b1; step = 16'd256;
    tag = "saw_up";
    repeat (600) tick();
    func = 3'd2; tag = "triangle";
    repeat (600) tick();
    func = 3'd5; duty = 8'd64; tag = "pulse";
    repeat (600) tick();
    func = 3'd0; sync_req = 1'b1; tag = "sync_saw";
    tick();
    sync_req = 1'b0;
    repeat (128) tick();
    func = 3'd1; tag = "switch_mid";
    repeat (400) tick();
    amp = 8'd127; func = 3'd3; tag = "square_amp127";
    repeat (600) tick();
    amp = 8'd0; tag = "amp_zero";
    repeat (20) tick();
    amp = 8'd255; step = 16'd1000; func = 3'd0; tag = "pre_sync";
    repeat (37) tick();
    func = 3'd2; sync_req = 1'b1; tag = "sync_mid";
    tick();
    sync_req = 1'b0;
    repeat (20) tick();
    func = 3'd6; step = 16'd256; sync_req = 1'b1; tag = "noise";
    tick();
    sync_req = 1'b0;
    repeat (50) tick();
    rst = 1'b1; tag = "rst_mid";
    tick();
    rst = 1'b0; sync_req = 1'b1; tag = "noise_again";
    tick();
    sync_req = 1'b0;
    repeat (50) tick();
    func = 3'd7; step = 16'd0; tag = "step_zero";
    repeat (30) tick();
    en = 1'b0; tag = "en_off";
    repeat (10) tick();
    tag = "random";
    repeat (2000) begin
      rst      = ($urandom_range(0, 299) == 0);
      en       = ($urandom_range(0, 7) != 0);
      sync_req = ($urandom_range(0, 39) == 0);
      func     = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0)
        step = 16'($urandom);
      else
        step = 16'($urandom_range(0, 2048));
      duty = 8'($urandom);
      amp  = 8'($urandom);
      tick();
    end
    @(posedge clk);
    #2;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_gen_param.md
Name: wave_gen_param

Overview:
- Parametrised successor to the 8-bit, 3-bit-select function generator.
- Phase-accumulator (DDS-style) generator with programmable frequency step, amplitude scaling, pulse duty and LFSR noise.
- Function changes are glitch-free: they take effect at the phase wrap.
- Feeds the DAC/display path in the Function Generator design.

Parameters:
- DATA_W, 8, output sample width (4..16).
- PHASE_W, 16, phase accumulator width (>= DATA_W+2).
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit noise LFSR.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance phase accumulator and LFSR.
- func  in  3  requested waveform select.
- step  in  PHASE_W  phase increment per enabled cycle (frequency word).
- duty  in  DATA_W  pulse threshold for func 101.
- amp  in  DATA_W  amplitude scale; all-ones means unity.
- sync_req  in  1  phase restart request.
- wave  out  DATA_W  scaled output sample.
- wave_valid  out  1  wave corresponds to an enabled phase step.
- wrap  out  1  one-cycle pulse on accumulator overflow.
- func_active  out  3  waveform currently being generated.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) sets:
  - acc=0, func_active=000, lfsr=LFSR_SEED;
  - raw=0, wave=0;
  - wave_valid=0, wrap=0, valid pipe=0.
- Reset mid-operation discards the pipeline contents; the pending function becomes 000.
- Accumulator:
  - en=1: acc <= (acc+step) mod 2^PHASE_W; wrap <= carry-out.
  - en=0: acc holds, wrap <= 0.
  - step=0 with en=1: acc holds and wrap never fires.
- sync_req=1 (priority over en):
  - acc <= 0, wrap <= 0;
  - func_active <= func in the same cycle.
- func_active update:
  - Loads func on a cycle where wrap is asserted (i.e. the cycle after overflow), or when en=0, or on sync_req.
  - Otherwise it holds, so a function change never truncates a period.
- Phase taps:
  - p = acc[PHASE_W-1 -: DATA_W].
  - q = acc[PHASE_W-1 -: DATA_W+1].
  - MAX = all-ones of width DATA_W.
- Stage 1 (raw register), selected by func_active:
  - 000 saw up: raw = p.
  - 001 saw down: raw = ~p.
  - 010 triangle: raw = q[DATA_W] ? ~q[DATA_W-1:0] : q[DATA_W-1:0].
  - 011 square: raw = p[DATA_W-1] ? MAX : 0.
  - 100 sine: see Optional Feature.
  - 101 pulse: raw = (p < duty) ? MAX : 0. duty=0 gives constant 0.
  - 110 noise: raw = lfsr[15 -: DATA_W] (or lfsr zero-extended when DATA_W>16 is excluded by parameter range).
    - Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifts on each en cycle.
  - 111 staircase: raw = p with all but its top 3 bits zeroed (8 steps).
- Stage 2: wave <= (raw * (amp+1)) >> DATA_W.
  - Intermediate width is 2*DATA_W+1.
  - amp=MAX is exact unity; amp=0 yields raw>>DATA_W, which is 0.
- Latency: wave reflects the acc value registered 2 cycles earlier.
- wave_valid is en delayed through a 2-stage pipe; it is cleared by rst.
- sync_req does not clear the valid pipe.
- Simultaneous wrap and sync_req: sync_req wins; acc=0, wrap=0.

Optional Feature:
- Macro WAVE_GEN_SINE_EN.
- Defined:
  - func 100 outputs sine from a 64-entry quarter-wave ROM indexed by p[DATA_W-3 -: 6] with quadrant mirroring/inversion via p[DATA_W-1:DATA_W-2].
  - ROM values are DATA_W-bit, offset-binary, midscale-centred.
- Not defined:
  - func 100 outputs constant midscale (1 << (DATA_W-1)).
  - No ROM is synthesised.

Decomposition:
- Package wave_gen_pkg holds:
  - the func encodings as named constants (FUNC_SAW_UP .. FUNC_STAIR);
  - the LFSR tap mask;
  - the default seed.
- One sub-module, wave_gen_sine_rom: quarter-wave ROM plus mirroring, instantiated only under WAVE_GEN_SINE_EN.

Test Plan:
- Bench configuration: DATA_W=8, PHASE_W=16.
- Reset, func=000, step=256, amp=255, en=1:
  - wave_valid rises 2 cycles after en;
  - wave counts 0,1,..,255,0;
  - wrap pulses every 256 cycles.
- func=010, step=256: wave goes 0,2,..,254, then 255,253,..,1; period 256 cycles.
- func=101, duty=64, step=256: wave=255 for 64 cycles, then 0 for 192 cycles, per period.
- func switches 000 to 001 at mid-period (acc=0x8000):
  - func_active stays 000 until the cycle after wrap;
  - then wave follows 255,254,...
- amp=127, func=011: high level is (255*128)>>8 = 127; low level is 0.
- sync_req mid-period: acc=0 next cycle, wrap stays 0, func_active=func.
- rst asserted mid-run: all outputs 0 the next cycle; lfsr restarts at 0xACE1, so noise repeats its initial sequence.
